// File: rtl/vid_stream_src.sv
// rtl/vid_stream_src.sv - frame-timing generator that streams grey pixels from memory with sync/de timing
module vid_stream_src #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ADDR_W   = 19
) (
    input  logic              pixelclk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_cont,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              o_vsync,
    output logic              o_hsync,
    output logic              o_de,
    output logic [7:0]        o_rgb,
    output logic              o_busy,
    output logic              o_frame_done
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    if (longint'(H_ACTIVE) * longint'(V_ACTIVE) > (longint'(1) << ADDR_W)) begin : g_addr_w_check
        $error("vid_stream_src: H_ACTIVE*V_ACTIVE does not fit in ADDR_W bits");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [ADDR_W-1:0] addr_cnt;

    logic run, h_last, v_last, last_pos, de, hsync, vsync;
    logic hsync_d1, vsync_d1, last_d1, run_d1, run_d2;

    assign run      = (state == RUN);
    assign h_last   = (int'(h_cnt) == H_TOTAL - 1);
    assign v_last   = (int'(v_cnt) == V_TOTAL - 1);
    assign last_pos = run && h_last && v_last;
    assign de       = run && (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    assign hsync    = run && (int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    assign vsync    = run && (int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);

    // addr_cnt holds the linear address of the current de position; only de cycles advance it
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            h_cnt    <= '0;
            v_cnt    <= '0;
            addr_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state    <= RUN;
                        h_cnt    <= '0;
                        v_cnt    <= '0;
                        addr_cnt <= '0;
                    end
                end
                RUN: begin
                    if (de)
                        addr_cnt <= addr_cnt + ADDR_W'(1);
                    if (h_last) begin
                        h_cnt <= '0;
                        if (v_last) begin
                            v_cnt    <= '0;
                            addr_cnt <= '0;
                            if (!i_cont)
                                state <= IDLE;
                        end else begin
                            v_cnt <= v_cnt + VW'(1);
                        end
                    end else begin
                        h_cnt <= h_cnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage output pipeline; memory data for a read launched in stage 1 is captured in stage 2
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            hsync_d1     <= 1'b0;
            vsync_d1     <= 1'b0;
            last_d1      <= 1'b0;
            run_d1       <= 1'b0;
            o_de         <= 1'b0;
            o_hsync      <= 1'b0;
            o_vsync      <= 1'b0;
            o_frame_done <= 1'b0;
            o_rgb        <= 8'h00;
            run_d2       <= 1'b0;
        end else begin
            mem_rd_en    <= de;
            mem_addr     <= de ? addr_cnt : '0;
            hsync_d1     <= hsync;
            vsync_d1     <= vsync;
            last_d1      <= last_pos;
            run_d1       <= run;
            o_de         <= mem_rd_en;
            o_hsync      <= hsync_d1;
            o_vsync      <= vsync_d1;
            o_frame_done <= last_d1;
            o_rgb        <= mem_rd_en ? mem_rdata : 8'h00;
            run_d2       <= run_d1;
        end
    end

    assign o_busy = run || run_d1 || run_d2;

endmodule

// File: tb/tb_vid_stream_src.sv
// tb/tb_vid_stream_src.sv - directed self-checking bench for vid_stream_src on an 8x6 timing
module tb_vid_stream_src;
    logic       pixelclk = 1'b0;
    logic       reset_n  = 1'b0;
    logic       i_start  = 1'b0;
    logic       i_cont   = 1'b0;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       o_vsync, o_hsync, o_de, o_busy, o_frame_done;
    logic [7:0] o_rgb;
    logic [31:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    vid_stream_src #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .ADDR_W(8)
    ) dut (
        .pixelclk(pixelclk), .reset_n(reset_n), .i_start(i_start), .i_cont(i_cont),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de), .o_rgb(o_rgb),
        .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    always #5 pixelclk = ~pixelclk;

    // Memory returns data = address for a strobed read; 0xFF exposes any unstrobed capture
    assign mem_rdata = mem_rd_en ? mem_addr : 8'hFF;
    assign obs = {10'd0, o_busy, mem_rd_en, mem_addr, o_de, o_hsync, o_vsync, o_frame_done, o_rgb};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Frame position (0..47) held internally during sample index q, or -1 when not running
    function automatic int ipos(input int q, input int nf, input int f2);
        if (q >= 1 && q <= 48) return q - 1;
        if (nf == 2 && q >= f2 && q < f2 + 48) return q - f2;
        return -1;
    endfunction

    function automatic logic [31:0] exp_vec(input int j, input int nf, input int f2);
        int pr, po, last;
        logic busy, rd, de, hs, vs, fd;
        logic [7:0] a, rgb;
        pr   = ipos(j - 1, nf, f2);
        po   = ipos(j - 2, nf, f2);
        rd   = (pr >= 0) && (pr % 8 < 4) && (pr / 8 < 3);
        a    = rd ? 8'((pr / 8) * 4 + pr % 8) : 8'd0;
        de   = (po >= 0) && (po % 8 < 4) && (po / 8 < 3);
        hs   = (po >= 0) && (po % 8 >= 5) && (po % 8 < 7);
        vs   = (po >= 0) && (po / 8 == 4);
        fd   = (po == 47);
        rgb  = de ? 8'((po / 8) * 4 + po % 8) : 8'd0;
        last = (nf == 2) ? f2 + 47 : 48;
        busy = (j >= 1) && (j <= last + 2);
        return {10'd0, busy, rd, a, de, hs, vs, fd, rgb};
    endfunction

    // Index 0 is the cycle i_start is high; f2 is the sample index where frame 2 is at (0,0)
    task automatic run_scn(input string tag, input int nf, input int f2, input logic cont0,
                           input int cont_drop, input int xs1, input int xs2);
        int len, last, de_n, hs_n, vs_n, fd_n, fd_first, busy_last, de_first, de_second;
        last = (nf == 2) ? f2 + 47 : 48;
        len  = last + 6;
        de_n = 0; hs_n = 0; vs_n = 0; fd_n = 0;
        fd_first = -1; busy_last = -1; de_first = -1; de_second = -1;
        for (int j = 0; j < len; j++) begin
            @(negedge pixelclk);
            check($sformatf("%s_cyc%0d", tag, j), obs, exp_vec(j, nf, f2));
            if (o_de) begin
                de_n++;
                if (de_first < 0) de_first = j;
                if (de_second < 0 && fd_n == 1) de_second = j;
            end
            if (o_hsync) hs_n++;
            if (o_vsync) vs_n++;
            if (o_frame_done) begin
                fd_n++;
                if (fd_first < 0) fd_first = j;
            end
            if (o_busy) busy_last = j;
            i_start = (j == 0) || (j == xs1) || (j == xs2);
            if (j == 0) i_cont = cont0;
            if (j == cont_drop) i_cont = 1'b0;
        end
        i_start = 1'b0;
        i_cont  = 1'b0;
        check({tag, "_de_count"}, 32'(de_n), 32'(12 * nf));
        check({tag, "_hsync_count"}, 32'(hs_n), 32'(12 * nf));
        check({tag, "_vsync_count"}, 32'(vs_n), 32'(8 * nf));
        check({tag, "_done_count"}, 32'(fd_n), 32'(nf));
        check({tag, "_done_first"}, 32'(fd_first), 32'd50);
        check({tag, "_busy_last"}, 32'(busy_last), 32'(last + 2));
        if (nf == 2)
            check({tag, "_frame_gap"}, 32'(de_second - de_first), 32'(f2 - 1));
    endtask

    initial begin
        repeat (2) @(negedge pixelclk);
        check("reset_hold", obs, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge pixelclk);
        check("idle_wait", obs, 32'd0);

        run_scn("single", 1, 0, 1'b0, -1, -1, -1);
        run_scn("start_ignore", 1, 0, 1'b0, -1, 20, 48);
        run_scn("cont", 2, 49, 1'b1, 58, -1, -1);
        run_scn("cont_drop", 1, 0, 1'b1, 10, -1, -1);
        run_scn("drain_restart", 2, 50, 1'b0, -1, 49, -1);

        @(negedge pixelclk);
        i_start = 1'b1;
        @(negedge pixelclk);
        i_start = 1'b0;
        repeat (19) @(negedge pixelclk);
        #2 reset_n = 1'b0;
        #1 check("reset_async", obs, 32'd0);
        repeat (2) @(negedge pixelclk);
        check("reset_mid_hold", obs, 32'd0);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge pixelclk);
            check($sformatf("post_reset_idle%0d", k), obs, 32'd0);
        end
        run_scn("after_reset", 1, 0, 1'b0, -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vid_stream_src.md
VID_STREAM_SRC -- requirements
Module: vid_stream_src

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, meaning horizontal front-porch pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, meaning horizontal sync-pulse pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, meaning horizontal back-porch pixels.
REQ-005 The block SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2 and V_BP 33, meaning the equivalent vertical line counts.
REQ-006 The block SHALL have parameter ADDR_W, default 19, meaning the pixel-memory address width.
REQ-007 pixelclk  input  1  pixel clock; all state SHALL update on its rising edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 i_start  input  1  single-cycle frame-start request.
REQ-010 i_cont  input  1  continuous mode; when high, frames repeat back-to-back.
REQ-011 mem_rd_en  output  1  pixel-memory read strobe.
REQ-012 mem_addr  output  ADDR_W  pixel-memory read address.
REQ-013 mem_rdata  input  8  pixel-memory data, valid exactly 1 cycle after the mem_rd_en/mem_addr cycle.
REQ-014 o_vsync, o_hsync, o_de  output  1 each  active-high video timing for the downstream edge-detection pipeline.
REQ-015 o_rgb  output  8  grey pixel data.
REQ-016 o_busy  output  1  high while a frame is being generated.
REQ-017 o_frame_done  output  1  single-cycle pulse marking the last position of a frame.

Function
REQ-018 The block SHALL use H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP, with counters h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1.
REQ-019 The FSM SHALL have two states: IDLE and RUN.
REQ-020 In IDLE, i_start=1 SHALL move the FSM to RUN with h_cnt=0 and v_cnt=0 on the next cycle.
REQ-021 In RUN, h_cnt SHALL increment every cycle and wrap at H_TOTAL-1; v_cnt SHALL increment on each h_cnt wrap and wrap at V_TOTAL-1.
REQ-022 At h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, the FSM SHALL stay in RUN and restart at (0,0) if i_cont=1, and SHALL return to IDLE otherwise.
REQ-023 i_start SHALL be ignored while in RUN.
REQ-024 A change of i_cont mid-frame SHALL take effect only at the frame end.
REQ-025 Internal de SHALL be RUN && h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
REQ-026 Internal hsync SHALL be RUN && H_ACTIVE+H_FP<=h_cnt<H_ACTIVE+H_FP+H_SYNC, on every line including blanking lines.
REQ-027 Internal vsync SHALL be RUN && V_ACTIVE+V_FP<=v_cnt<V_ACTIVE+V_FP+V_SYNC, high for whole lines.
REQ-028 mem_rd_en SHALL be registered internal de, giving 1 cycle of delay.
REQ-029 mem_addr SHALL be a registered linear address equal to v_cnt*H_ACTIVE+h_cnt, implemented as an incrementing counter with no multiplier.
REQ-030 mem_addr SHALL be cleared to 0 at every frame start and SHALL advance only on de cycles.
REQ-031 o_vsync, o_hsync and o_de SHALL equal the internal timing delayed by exactly 2 cycles.
REQ-032 o_rgb SHALL be registered mem_rdata when the 1-cycle-delayed de is high, and 0x00 otherwise.
REQ-033 o_frame_done SHALL be the last-position condition (REQ-022) delayed 2 cycles, for a 1-cycle pulse.
REQ-034 o_busy SHALL equal (state==RUN) or a nonzero 2-stage pipeline, so it stays high until the last position has left the outputs.
REQ-035 An i_start arriving while o_busy is high only because of draining (FSM already in IDLE) SHALL be accepted, and the new frame's timing SHALL follow gaplessly.
REQ-036 All address arithmetic SHALL be unsigned, and H_ACTIVE*V_ACTIVE SHALL fit in ADDR_W bits; this is a static parameter check.

Reset
REQ-037 reset_n low SHALL, asynchronously and at any time including mid-frame, force IDLE, clear counters and pipeline, and drive every output to 0.
REQ-038 After reset release, the block SHALL wait for i_start.

Verification
(bench params: H 4/1/2/1 for H_TOTAL=8; V 3/1/1/1 for V_TOTAL=6; memory returns data=addr)
REQ-039 Single-frame scenario: i_start pulse with i_cont=0 -> o_de high 12 cycles total, 4 per line in 3 groups; o_rgb sequence 0x00..0x0B; o_frame_done once, 50 cycles after start accept; then idle.
REQ-040 Sync-timing scenario: during the frame -> o_hsync high 2 cycles per line, starting 5 cycles after line start (output time), 6 times per frame; o_vsync high for 8 consecutive cycles starting on line 4.
REQ-041 Continuous-mode scenario: i_cont=1 -> second frame's first o_de occurs exactly 48 cycles after the first frame's first o_de; mem_addr restarts at 0; o_busy never drops.
REQ-042 Mid-frame i_cont drop: i_cont falls on line 1 -> the current frame completes fully, no second frame starts, and o_busy falls 2 cycles after the FSM enters IDLE.
REQ-043 Start-ignore scenario: i_start pulses during RUN -> no counter disturbance; output identical to REQ-039.
REQ-044 Reset mid-frame: reset_n low at line 2 -> all outputs 0 immediately; after release, outputs stay 0 until a new i_start, after which a frame exactly matching REQ-039 follows.
